// File: rtl/camera_pkg.sv
// Shared types and default constants for the exposure timer controller and the exposure FSM bench.
package camera_pkg;

  typedef enum logic [1:0] {IDLE, ARM, EXPOSE, READOUT} exp_state_t;

  localparam int unsigned EXP_W_DEF       = 5;
  localparam int unsigned EXP_MIN_DEF     = 2;
  localparam int unsigned EXP_MAX_DEF     = 30;
  localparam int unsigned EXP_DEFAULT_DEF = 2;
  localparam int unsigned TICK_DIV_DEF    = 1000;
  localparam int unsigned HOLDOFF_DEF     = 4;

  // Saturating one-unit step; simultaneous up and down cancel out.
  function automatic int unsigned exp_step(input int unsigned cur, input logic up, input logic dn,
                                           input int unsigned lo, input int unsigned hi);
    int unsigned r;
    r = cur;
    if (up && !dn && cur < hi)      r = cur + 1;
    else if (dn && !up && cur > lo) r = cur - 1;
    return r;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: pulses for the cycle in which the input is high after being low.
module edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_edge
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_d;
  end

  assign o_edge = i_d & ~r_q;

endmodule

// File: rtl/exposure_timer_ctrl.sv
// Exposure timer controller: owns the exposure setting, issues Init, times EXPOSE and raises Ovf5.
// Optional feature macro CONT_MODE_EN adds i_continuous for back-to-back captures.
module exposure_timer_ctrl
  import camera_pkg::*;
#(
  parameter int unsigned EXP_W       = EXP_W_DEF,
  parameter int unsigned EXP_MIN     = EXP_MIN_DEF,
  parameter int unsigned EXP_MAX     = EXP_MAX_DEF,
  parameter int unsigned EXP_DEFAULT = EXP_DEFAULT_DEF,
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned HOLDOFF     = HOLDOFF_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_init_req,
  input  logic             i_exp_increase,
  input  logic             i_exp_decrease,
  input  logic             i_start,
`ifdef CONT_MODE_EN
  input  logic             i_continuous,
`endif
  output logic             o_init,
  output logic             o_ovf5,
  output logic [EXP_W-1:0] o_exp_time,
  output logic             o_busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF);
  localparam int unsigned NUM_ED  = 3;
  localparam int unsigned ED_INIT = 0;
  localparam int unsigned ED_INC  = 1;
  localparam int unsigned ED_DEC  = 2;

  exp_state_t       r_state, w_state_nxt;
  logic [EXP_W-1:0] r_exp, w_exp_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic [EXP_W-1:0] r_unit, w_unit_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic             r_init, w_init_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy;
  logic             w_go_cont;
  logic             w_pend_nxt;

  logic [NUM_ED-1:0] w_lvl, w_edge;
  assign w_lvl = {i_exp_decrease, i_exp_increase, i_init_req};

  for (genvar g = 0; g < NUM_ED; g++) begin : g_ed
    edge_detect u_ed (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    (w_lvl[g]),
      .o_edge (w_edge[g])
    );
  end

`ifdef CONT_MODE_EN
  logic r_cont_pend;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cont_pend <= 1'b0;
    else          r_cont_pend <= w_pend_nxt;
  end
  assign w_go_cont = r_cont_pend;
`else
  assign w_go_cont = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_presc_nxt = r_presc;
    w_unit_nxt  = r_unit;
    w_hold_nxt  = r_hold;
    w_init_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_pend_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_exp_nxt = EXP_W'(exp_step(32'(r_exp), w_edge[ED_INC], w_edge[ED_DEC], EXP_MIN, EXP_MAX));
        if (w_edge[ED_INIT] || w_go_cont) begin
          w_init_nxt  = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (i_start) begin
          w_state_nxt = EXPOSE;
          w_presc_nxt = '0;
          w_unit_nxt  = '0;
        end
      end
      EXPOSE: begin
        // An abort wins over a coincident final tick: Ovf5 must never follow a dropped Start.
        if (!i_start) begin
          w_state_nxt = READOUT;
          w_hold_nxt  = HOLD_LOAD;
        end else if (r_presc == PRESC_LAST) begin
          w_presc_nxt = '0;
          w_unit_nxt  = r_unit + EXP_W'(1);
          if (r_unit == r_exp - EXP_W'(1)) begin
            w_ovf_nxt   = 1'b1;
            w_state_nxt = READOUT;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      READOUT: begin
        // Ovf5 high marks the wait-for-Start-low phase; low means holdoff is running.
        if (r_ovf) begin
          if (!i_start) begin
            w_ovf_nxt  = 1'b0;
            w_hold_nxt = HOLD_LOAD;
          end
        end else if (r_hold <= HW'(1)) begin
          w_hold_nxt  = '0;
          w_state_nxt = IDLE;
`ifdef CONT_MODE_EN
          w_pend_nxt  = i_continuous;
`endif
        end else begin
          w_hold_nxt = r_hold - HW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_exp   <= EXP_W'(EXP_DEFAULT);
      r_presc <= '0;
      r_unit  <= '0;
      r_hold  <= '0;
      r_init  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_presc <= w_presc_nxt;
      r_unit  <= w_unit_nxt;
      r_hold  <= w_hold_nxt;
      r_init  <= w_init_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign o_init     = r_init;
  assign o_ovf5     = r_ovf;
  assign o_exp_time = r_exp;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Directed bench for exposure_timer_ctrl with TICK_DIV=2, HOLDOFF=4; vector table plus corner sequences.
module tb_exposure_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0, dec = 1'b0, req = 1'b0, start = 1'b0;
  logic       init, ovf, busy;
  logic [4:0] exp_time;
`ifdef CONT_MODE_EN
  logic       cont = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exposure_timer_ctrl #(.TICK_DIV(2), .HOLDOFF(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_init_req    (req),
    .i_exp_increase(inc),
    .i_exp_decrease(dec),
    .i_start       (start),
`ifdef CONT_MODE_EN
    .i_continuous  (cont),
`endif
    .o_init        (init),
    .o_ovf5        (ovf),
    .o_exp_time    (exp_time),
    .o_busy        (busy)
  );

  // in = {inc, dec, req, start}; out = {init, ovf, busy}
  typedef struct {
    logic [3:0] in;
    logic [4:0] exp;
    logic [2:0] out;
  } vec_t;

  vec_t vec[34];

  function automatic vec_t mk(input logic [3:0] in, input logic [4:0] e, input logic [2:0] o);
    vec_t v;
    v.in = in; v.exp = e; v.out = o;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int e_exp, input logic [2:0] o);
    chk({nm, ".exp"},  int'(exp_time), e_exp);
    chk({nm, ".init"}, int'(init), int'(o[2]));
    chk({nm, ".ovf"},  int'(ovf),  int'(o[1]));
    chk({nm, ".busy"}, int'(busy), int'(o[0]));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      {inc, dec, req, start} = vec[i].in;
      step();
      chk_out($sformatf("v%0d", i), int'(vec[i].exp), vec[i].out);
    end
  endtask

  task automatic pulse_inc();
    inc = 1'b1; step();
    inc = 1'b0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    // Adjustment table, starting from the reset value 2.
    vec[0]  = mk(4'b1000, 5'd3, 3'b000);
    vec[1]  = mk(4'b1000, 5'd3, 3'b000);
    vec[2]  = mk(4'b0000, 5'd3, 3'b000);
    vec[3]  = mk(4'b1000, 5'd4, 3'b000);
    vec[4]  = mk(4'b0000, 5'd4, 3'b000);
    vec[5]  = mk(4'b1000, 5'd5, 3'b000);
    vec[6]  = mk(4'b0000, 5'd5, 3'b000);
    vec[7]  = mk(4'b0100, 5'd4, 3'b000);
    vec[8]  = mk(4'b0000, 5'd4, 3'b000);
    vec[9]  = mk(4'b0100, 5'd3, 3'b000);
    vec[10] = mk(4'b0000, 5'd3, 3'b000);
    vec[11] = mk(4'b0100, 5'd2, 3'b000);
    vec[12] = mk(4'b0000, 5'd2, 3'b000);
    vec[13] = mk(4'b0100, 5'd2, 3'b000);
    vec[14] = mk(4'b0000, 5'd2, 3'b000);
    vec[15] = mk(4'b1100, 5'd2, 3'b000);
    vec[16] = mk(4'b0000, 5'd2, 3'b000);
    // Capture at 2 with a simultaneous inc: exposure runs at 3 units = 6 cycles.
    vec[17] = mk(4'b1010, 5'd3, 3'b101);
    vec[18] = mk(4'b0000, 5'd3, 3'b001);
    vec[19] = mk(4'b0001, 5'd3, 3'b001);
    vec[20] = mk(4'b1011, 5'd3, 3'b001);
    vec[21] = mk(4'b0001, 5'd3, 3'b001);
    vec[22] = mk(4'b1011, 5'd3, 3'b001);
    vec[23] = mk(4'b0001, 5'd3, 3'b001);
    vec[24] = mk(4'b0001, 5'd3, 3'b001);
    vec[25] = mk(4'b0001, 5'd3, 3'b011);
    vec[26] = mk(4'b0011, 5'd3, 3'b011);
    vec[27] = mk(4'b0001, 5'd3, 3'b011);
    vec[28] = mk(4'b0000, 5'd3, 3'b001);
    vec[29] = mk(4'b0000, 5'd3, 3'b001);
    vec[30] = mk(4'b0000, 5'd3, 3'b001);
    vec[31] = mk(4'b0000, 5'd3, 3'b001);
    vec[32] = mk(4'b0000, 5'd3, 3'b000);
    vec[33] = mk(4'b0000, 5'd3, 3'b000);

    step(); step();
    chk_out("reset", 2, 3'b000);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 2, 3'b000);

    run_vecs(0, 16);

    // Saturation at the top end.
    for (int k = 0; k < 28; k++) pulse_inc();
    chk("sat.reach30", int'(exp_time), 30);
    pulse_inc();
    chk("sat.inc_at30", int'(exp_time), 30);
    inc = 1'b1; dec = 1'b1; step();
    chk("sat.both_at30", int'(exp_time), 30);
    inc = 1'b0; dec = 1'b0; step();
    dec = 1'b1; step();
    chk("sat.dec_from30", int'(exp_time), 29);
    dec = 1'b0; step();

    // Asynchronous reset while idle restores the default setting without a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_out("areset_idle", 2, 3'b000);
    rst_n = 1'b1;
    step();

    run_vecs(17, 33);

    // Abort: Start drops in EXPOSE; Ovf5 must stay low, Busy clears after holdoff.
    req = 1'b1; step();
    chk_out("abort.init", 3, 3'b101);
    req = 1'b0; start = 1'b1; step();
    step(); step();
    start = 1'b0; step();
    chk_out("abort.drop", 3, 3'b001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("abort.hold%0d", k), 3, 3'b001);
    end
    step();
    chk_out("abort.idle", 3, 3'b000);
    step(); step(); step();
    chk_out("abort.late", 3, 3'b000);

    // Reset mid-capture with Ovf5 high: outputs drop before any clock edge.
    req = 1'b1; step();
    req = 1'b0; start = 1'b1; step();
    for (int k = 0; k < 6; k++) step();
    chk_out("mid.ovf_up", 3, 3'b011);
    #2 rst_n = 1'b0;
    #1 chk_out("mid.areset", 2, 3'b000);
    start = 1'b0; rst_n = 1'b1;
    step();
    chk_out("mid.release", 2, 3'b000);

    // Reset while Init is high: Init drops asynchronously.
    req = 1'b1; step();
    chk("init_rst.pre", int'(init), 1);
    #2 rst_n = 1'b0;
    #1 chk_out("init_rst.areset", 2, 3'b000);
    req = 1'b0; rst_n = 1'b1;
    step();
    chk_out("init_rst.release", 2, 3'b000);

`ifdef CONT_MODE_EN
    // Continuous: a second Init follows one idle cycle after holdoff, with no new request.
    cont = 1'b1;
    req = 1'b1; step();
    chk_out("cont.init1", 2, 3'b101);
    req = 1'b0; start = 1'b1; step();
    start = 1'b0; step();
    chk_out("cont.abort", 2, 3'b001);
    step(); step(); step();
    chk_out("cont.hold", 2, 3'b001);
    step();
    chk_out("cont.idle", 2, 3'b000);
    step();
    chk_out("cont.init2", 2, 3'b101);
    cont = 1'b0; start = 1'b1; step();
    start = 1'b0; step();
    step(); step(); step(); step();
    chk_out("cont.off_idle", 2, 3'b000);
    step();
    chk_out("cont.off_noinit", 2, 3'b000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
